// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registered ALU control decoder acting as a valid/ready stage
// between decode and execute. It turns ALUOp/funct3/funct7 into a 5-bit ALU op,
// carries a destination tag and flags illegal encodings.
// Optional feature macro: ALU_ISSUE_MEXT_EN. When it is defined, M-extension ops
// are decoded and held for MUL_LAT/DIV_LAT cycles, and upstream is stalled while
// one is in flight. Without it, funct7=0000001 R-type is treated as illegal and
// the multi-cycle machinery (MC state, counter, busy) does not exist.
module alu_issue_ctrl #(
  parameter int TAGW    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_src,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_op,
  output logic [TAGW-1:0] out_tag,
  output logic            out_mc,
  output logic            illegal,
  output logic            busy
);

  localparam logic [4:0] OpAnd  = 5'b00000;
  localparam logic [4:0] OpOr   = 5'b00001;
  localparam logic [4:0] OpAdd  = 5'b00010;
  localparam logic [4:0] OpXor  = 5'b00011;
  localparam logic [4:0] OpSll  = 5'b00100;
  localparam logic [4:0] OpSrl  = 5'b00101;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpSra  = 5'b00111;
  localparam logic [4:0] OpSlt  = 5'b01000;
  localparam logic [4:0] OpSltu = 5'b01001;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
`ifdef ALU_ISSUE_MEXT_EN
  localparam logic [6:0] F7Mext = 7'b0000001;
  localparam int MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CntW   = $clog2(MaxLat + 1);
`endif

  // Latencies below one cycle cannot be represented by the countdown.
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_latCheck
    $error("alu_issue_ctrl: MUL_LAT and DIV_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FULL = 2'd1
`ifdef ALU_ISSUE_MEXT_EN
    , S_MC = 2'd2
`endif
  } stateT;

  stateT            r_state, w_stateNext;
  logic [4:0]       r_aluOp, w_aluOpNext;
  logic [TAGW-1:0]  r_tag, w_tagNext;
  logic             r_illegal, w_illegalNext;
  logic [4:0]       w_baseOp;
  logic [4:0]       w_decOp;
  logic             w_decIll;
  logic             w_accept;
`ifdef ALU_ISSUE_MEXT_EN
  logic             r_mc, w_mcNext;
  logic [CntW-1:0]  r_cnt, w_cntNext;
  logic             w_decM;
  logic [CntW-1:0]  w_latM1;
`endif

  // Handshake: a held result frees the stage only when it leaves this cycle.
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_FULL) && out_ready);
  assign out_valid = (r_state == S_FULL);
  assign w_accept  = in_valid && in_ready;

  assign alu_op  = r_aluOp;
  assign out_tag = r_tag;
  assign illegal = r_illegal;
`ifdef ALU_ISSUE_MEXT_EN
  assign out_mc  = r_mc;
  assign busy    = (r_state == S_MC);
  assign w_latM1 = funct3[2] ? CntW'(DIV_LAT - 1) : CntW'(MUL_LAT - 1);
`else
  assign out_mc  = 1'b0;
  assign busy    = 1'b0;
`endif

  // Plain funct3 mapping shared by R-type and I-type arithmetic.
  always_comb begin
    w_baseOp = OpAnd;
    case (funct3)
      3'b000:  w_baseOp = OpAdd;
      3'b001:  w_baseOp = OpSll;
      3'b010:  w_baseOp = OpSlt;
      3'b011:  w_baseOp = OpSltu;
      3'b100:  w_baseOp = OpXor;
      3'b101:  w_baseOp = OpSrl;
      3'b110:  w_baseOp = OpOr;
      default: w_baseOp = OpAnd;
    endcase
  end

  // Full decode of the incoming instruction fields; illegal forms become ADD.
  always_comb begin
    w_decOp  = OpAdd;
    w_decIll = 1'b0;
`ifdef ALU_ISSUE_MEXT_EN
    w_decM   = 1'b0;
`endif
    case (alu_src)
      2'b00: w_decOp = OpAdd;
      2'b01: w_decOp = OpSub;
      2'b10: begin
        case (funct7)
          F7Base: w_decOp = w_baseOp;
          F7Alt: begin
            if (funct3 == 3'b000)      w_decOp = OpSub;
            else if (funct3 == 3'b101) w_decOp = OpSra;
            else                       w_decIll = 1'b1;
          end
`ifdef ALU_ISSUE_MEXT_EN
          F7Mext: begin
            w_decOp = {2'b10, funct3};
            w_decM  = 1'b1;
          end
`endif
          default: w_decIll = 1'b1;
        endcase
      end
      default: begin
        w_decOp = w_baseOp;
        if (funct3 == 3'b001 && funct7 != F7Base) begin
          w_decIll = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7Alt)        w_decOp = OpSra;
          else if (funct7 != F7Base)  w_decIll = 1'b1;
        end
      end
    endcase
    if (w_decIll) begin
      w_decOp = OpAdd;
    end
  end

  // Next-state and captured output fields for the IDLE/MC/FULL machine.
  always_comb begin
    w_stateNext   = r_state;
    w_aluOpNext   = r_aluOp;
    w_tagNext     = r_tag;
    w_illegalNext = r_illegal;
`ifdef ALU_ISSUE_MEXT_EN
    w_mcNext      = r_mc;
    w_cntNext     = r_cnt;
`endif
    if (w_accept) begin
      w_aluOpNext   = w_decOp;
      w_tagNext     = in_tag;
      w_illegalNext = w_decIll;
      w_stateNext   = S_FULL;
`ifdef ALU_ISSUE_MEXT_EN
      w_mcNext      = w_decM;
      w_cntNext     = '0;
      if (w_decM && (w_latM1 != '0)) begin
        w_stateNext = S_MC;
        w_cntNext   = w_latM1;
      end
`endif
    end else if ((r_state == S_FULL) && out_ready) begin
      w_stateNext = S_IDLE;
    end
`ifdef ALU_ISSUE_MEXT_EN
    else if (r_state == S_MC) begin
      if (r_cnt == CntW'(1)) begin
        w_stateNext = S_FULL;
        w_cntNext   = '0;
      end else begin
        w_cntNext = r_cnt - CntW'(1);
      end
    end
`endif
  end

  // State register; reset drops any in-flight or presented op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_aluOp   <= '0;
      r_tag     <= '0;
      r_illegal <= 1'b0;
`ifdef ALU_ISSUE_MEXT_EN
      r_mc      <= 1'b0;
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_aluOp   <= w_aluOpNext;
      r_tag     <= w_tagNext;
      r_illegal <= w_illegalNext;
`ifdef ALU_ISSUE_MEXT_EN
      r_mc      <= w_mcNext;
      r_cnt     <= w_cntNext;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. Expected ops come from an independent decode
// model and are queued at each accept, then compared when the DUT hands off.
// Scenario tasks add their own latency/hold/reset comparisons inline.
module tb_alu_issue_ctrl;

  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_src;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      alu_op;
  logic [TAGW-1:0] out_tag;
  logic            out_mc;
  logic            illegal;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]      op;
    logic [TAGW-1:0] tag;
    logic            mc;
    logic            ill;
  } expT;

  expT sbQ[$];

  alu_issue_ctrl #(.TAGW(TAGW), .MUL_LAT(3), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src(alu_src), .funct3(funct3), .funct7(funct7), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .out_tag(out_tag), .out_mc(out_mc), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference decoder written from the encoding table.
  function automatic expT expModel(input logic [1:0] s, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [TAGW-1:0] t);
    expT e;
    logic [4:0] plain;
    case (f3)
      3'd0: plain = 5'b00010;
      3'd1: plain = 5'b00100;
      3'd2: plain = 5'b01000;
      3'd3: plain = 5'b01001;
      3'd4: plain = 5'b00011;
      3'd5: plain = 5'b00101;
      3'd6: plain = 5'b00001;
      default: plain = 5'b00000;
    endcase
    e.tag = t;
    e.mc  = 1'b0;
    e.ill = 1'b0;
    e.op  = plain;
    if (s == 2'b00) e.op = 5'b00010;
    else if (s == 2'b01) e.op = 5'b00110;
    else if (s == 2'b10) begin
      if (f7 == 7'h00) e.op = plain;
      else if (f7 == 7'h20 && f3 == 3'd0) e.op = 5'b00110;
      else if (f7 == 7'h20 && f3 == 3'd5) e.op = 5'b00111;
`ifdef ALU_ISSUE_MEXT_EN
      else if (f7 == 7'h01) begin
        e.op = {2'b10, f3};
        e.mc = 1'b1;
      end
`endif
      else e.ill = 1'b1;
    end else begin
      if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20) e.op = 5'b00111;
      else if (f3 == 3'd5 && f7 != 7'h00) e.ill = 1'b1;
    end
    if (e.ill) e.op = 5'b00010;
    return e;
  endfunction

  // Push the expected result whenever the DUT accepts a request.
  always @(negedge clk) begin
    if (rst) sbQ.delete();
    else if (in_valid && in_ready) sbQ.push_back(expModel(alu_src, funct3, funct7, in_tag));
  end

  // Pop and compare at every output handshake.
  always @(negedge clk) begin
    expT e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got op=%b tag=%0d with nothing queued", alu_op, out_tag);
      end else begin
        e = sbQ.pop_front();
        if ({alu_op, out_tag, out_mc, illegal} !== e) begin
          errors++;
          $display("[TB] FAIL sb_result: got op=%b tag=%0d mc=%b ill=%b, want op=%b tag=%0d mc=%b ill=%b",
                   alu_op, out_tag, out_mc, illegal, e.op, e.tag, e.mc, e.ill);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [TAGW-1:0] t);
    in_valid = v;
    alu_src  = s;
    funct3   = f3;
    funct7   = f7;
    in_tag   = t;
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    rst = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'd0, 7'h00, '0);
    tick();
    tick();
    obs = {out_valid, alu_op, out_tag, out_mc, illegal, busy, in_ready};
    checks++;
    if (obs !== {1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_held: got %b, want %b", obs, 19'b1);
    end
    rst = 1'b0;
    tick();
    tick();
    obs = {out_valid, alu_op, out_tag, out_mc, illegal, busy, in_ready};
    checks++;
    if (obs !== 19'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b, want %b", obs, 19'b1);
    end
    // Park an AND in FULL under backpressure, then reset it away.
    applyStimulus(1'b1, 2'b10, 3'd7, 7'h00, 5'd5);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, alu_op, out_tag, in_ready} !== {1'b1, 5'b00000, 5'd5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_preload: got v=%b op=%b tag=%0d rdy=%b, want v=1 op=00000 tag=5 rdy=0",
               out_valid, alu_op, out_tag, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {out_valid, alu_op, out_tag, out_mc, illegal, busy, in_ready};
    checks++;
    if (obs !== 19'b1) begin
      errors++;
      $display("[TB] FAIL reset_discard: got %b, want %b", obs, 19'b1);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_nothing_presented: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 3'd0, 7'h00, 5'd1);
    tick();
    applyStimulus(1'b1, 2'b10, 3'd0, 7'h20, 5'd2);
    checks++;
    if ({out_valid, alu_op, out_tag, in_ready} !== {1'b1, 5'b00010, 5'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_add: got v=%b op=%b tag=%0d rdy=%b, want 1 00010 1 1",
               out_valid, alu_op, out_tag, in_ready);
    end
    tick();
    applyStimulus(1'b1, 2'b10, 3'd5, 7'h20, 5'd3);
    checks++;
    if ({out_valid, alu_op, out_tag} !== {1'b1, 5'b00110, 5'd2}) begin
      errors++;
      $display("[TB] FAIL b2b_sub: got v=%b op=%b tag=%0d, want 1 00110 2", out_valid, alu_op, out_tag);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_op, out_tag} !== {1'b1, 5'b00111, 5'd3}) begin
      errors++;
      $display("[TB] FAIL b2b_sra: got v=%b op=%b tag=%0d, want 1 00111 3", out_valid, alu_op, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_decode_sweep();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'b10, 3'(i), 7'h00, 5'(i));
      tick();
      applyStimulus(1'b1, 2'b11, 3'(i), 7'h00, 5'(i + 8));
      tick();
    end
    applyStimulus(1'b1, 2'b00, 3'd5, 7'h7f, 5'd20);
    tick();
    applyStimulus(1'b1, 2'b01, 3'd3, 7'h20, 5'd21);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 3'd1, 7'h20, 5'd9);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, illegal, alu_op, out_mc} !== {1'b1, 1'b1, 5'b00010, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ill_itype_sll: got v=%b ill=%b op=%b mc=%b, want 1 1 00010 0",
               out_valid, illegal, alu_op, out_mc);
    end
    tick();
    applyStimulus(1'b1, 2'b10, 3'd0, 7'h02, 5'd10);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, illegal, alu_op} !== {1'b1, 1'b1, 5'b00010}) begin
      errors++;
      $display("[TB] FAIL ill_rtype_f7: got v=%b ill=%b op=%b, want 1 1 00010", out_valid, illegal, alu_op);
    end
    tick();
    applyStimulus(1'b1, 2'b11, 3'd0, 7'h20, 5'd11);
    tick();
    applyStimulus(1'b1, 2'b11, 3'd5, 7'h20, 5'd12);
    checks++;
    if ({illegal, alu_op} !== {1'b0, 5'b00010}) begin
      errors++;
      $display("[TB] FAIL itype_addi_f7: got ill=%b op=%b, want 0 00010", illegal, alu_op);
    end
    tick();
    applyStimulus(1'b1, 2'b10, 3'd1, 7'h20, 5'd13);
    tick();
    applyStimulus(1'b1, 2'b11, 3'd5, 7'h01, 5'd14);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

`ifdef ALU_ISSUE_MEXT_EN
  task automatic test_mext();
    int n;
    logic saw;
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 3'd0, 7'h01, 5'd7);
    tick();
    applyStimulus(1'b1, 2'b10, 3'd6, 7'h00, 5'd30);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL mul_wait t%0d: got busy=%b rdy=%b v=%b, want 1 0 0", c, busy, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_op, out_tag, out_mc, busy} !== {1'b1, 5'b10000, 5'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mul_out: got v=%b op=%b tag=%0d mc=%b busy=%b, want 1 10000 7 1 0",
               out_valid, alu_op, out_tag, out_mc, busy);
    end
    tick();
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 3'd4, 7'h01, 5'd12);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("[TB] FAIL div_latency: got %0d cycles, want 32", n);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, alu_op, out_tag, out_mc, busy, in_ready} !== {1'b1, 5'b10100, 5'd12, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL div_hold c%0d: got v=%b op=%b tag=%0d mc=%b busy=%b rdy=%b", c,
                 out_valid, alu_op, out_tag, out_mc, busy, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL div_release: got v=%b busy=%b rdy=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    applyStimulus(1'b1, 2'b10, 3'd4, 7'h01, 5'd3);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid || busy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_reset_discard: activity seen=%b, want 0", saw);
    end
    applyStimulus(1'b1, 2'b10, 3'd0, 7'h00, 5'd4);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_op, out_tag, out_mc, illegal} !== {1'b1, 5'b00010, 5'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_after_reset: got v=%b op=%b tag=%0d mc=%b ill=%b, want 1 00010 4 0 0",
               out_valid, alu_op, out_tag, out_mc, illegal);
    end
    tick();
  endtask
`else
  task automatic test_mext_off();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 3'd0, 7'h01, 5'd6);
    tick();
    applyStimulus(1'b1, 2'b10, 3'd4, 7'h01, 5'd8);
    checks++;
    if ({out_valid, alu_op, illegal, out_mc, busy} !== {1'b1, 5'b00010, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mext_off_mul: got v=%b op=%b ill=%b mc=%b busy=%b, want 1 00010 1 0 0",
               out_valid, alu_op, illegal, out_mc, busy);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, illegal, out_tag, busy} !== {1'b1, 1'b1, 5'd8, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mext_off_div: got v=%b ill=%b tag=%0d busy=%b, want 1 1 8 0",
               out_valid, illegal, out_tag, busy);
    end
    tick();
  endtask
`endif

  task automatic test_random_backpressure();
    logic [6:0] f7;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    f7, 5'($urandom_range(0, 31)));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (out_valid || busy); i++) tick();
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL random_drain: v=%b busy=%b still set after drain budget", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_decode_sweep();
    test_illegal();
`ifdef ALU_ISSUE_MEXT_EN
    test_mext();
`else
    test_mext_off();
`endif
    test_random_backpressure();
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: %0d expected results never presented, want 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
